down_counter_reload: RTL and testbench
======================================

Name: down_counter_reload

Overview:
- Synchronous, loadable down counter. It is the count-down counterpart of the team's ripple up counter.
- Built from a per-bit toggle flip-flop sub-module, all bits on a single clock.
- Provides one-shot and auto-reload timing: terminal-count pulse, busy indication, and sticky expiry/overrun flags.
- Used as the timebase/timeout block by controllers in the basic-blocks library.

Parameters:
WIDTH, 8, counter and load-value width in bits (min 2)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  count enable; one decrement per enabled clock in RUN
load  input  1  load strobe; captures load_val and mode_in
load_val  input  WIDTH  start/reload value
mode_in  input  1  0 = one-shot, 1 = auto-reload; sampled only on load
clr_flag  input  1  clears tc_flag and overrun
count  output  WIDTH  current counter value
tc  output  1  terminal-count pulse, one cycle, registered
busy  output  1  high while in RUN
tc_flag  output  1  sticky: set on tc
overrun  output  1  sticky: tc occurred while tc_flag already set

Behaviour:
- Reset (async, active-high), applies immediately:
  - count = 0, tc = 0, busy = 0, tc_flag = 0, overrun = 0.
  - reload_reg = 0, mode_reg = 0, state = IDLE.
- States: IDLE, RUN, DONE. busy = (state == RUN), driven directly from a state register bit (no glitch).
- Priority each cycle: load > en-step > hold.
- load = 1 (any state, en ignored that cycle):
  - reload_reg <= load_val, mode_reg <= mode_in, count <= load_val.
  - If load_val != 0: state <= RUN, tc <= 0.
  - If load_val == 0 and mode_in == 0: state <= DONE, tc <= 1 (immediate expiry).
  - If load_val == 0 and mode_in == 1: state <= RUN, tc <= 0.
- RUN, en = 1, no load:
  - count > 0: count <= count - 1.
  - count == 0 and mode_reg == 1: count <= reload_reg.
  - count == 0 and mode_reg == 0: cannot occur (one-shot leaves RUN on reaching 0).
  - tc <= 1 iff the new count == 0; otherwise tc <= 0.
  - One-shot: when the new count == 0, state <= DONE in the same edge.
  - Auto-reload period = reload_reg + 1 enabled cycles. reload_reg == 0 gives tc on every enabled cycle.
- RUN, en = 0: count, state and mode held; tc <= 0. A tc pulse is never stretched by stalls.
- IDLE / DONE without load: count held (DONE holds 0), en ignored, tc <= 0.
- Decrement uses per-bit toggle logic: bit i toggles when en-step and bits [i-1:0] are all 0. No wrap below 0 in one-shot.
- Flags, updated on the same edge as tc:
  - tc_flag_next = tc_set | (tc_flag & ~clr_flag); tc_set wins over simultaneous clr_flag.
  - overrun_next = (tc_set & tc_flag & ~clr_flag) | (overrun & ~clr_flag).
  - tc_set = the condition that sets tc this edge.
- Latency: count, tc, flags and busy all update on the edge after the causing input. No combinational input-to-output paths.
- Reset asserted mid-count: immediate return to the reset values above. The counter stays in IDLE after reset deassertion until the next load.

Decomposition:
- Shared package `counter_pkg`:
  - state encoding constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2.
  - mode constants MODE_ONESHOT = 1'b0, MODE_RELOAD = 1'b1.
  - default width constant CNT_W_DEFAULT = 8.
- Sub-module `tff_sync`:
  - ports: clk, reset (async active-high), t, d_load, ld, q.
  - ld has priority: q <= d_load; otherwise q toggles when t.
- Top instantiates WIDTH copies of tff_sync and drives each t from the borrow chain. The FSM, reload register, tc and flags live in the top.

Test Plan:
- Reset mid-count: load 8'd5 mode 0, en = 1 for 2 cycles, assert reset -> count = 0, busy = 0, tc = 0, flags = 0 immediately; state stays IDLE after release.
- One-shot: load 8'd3 mode 0, en = 1 -> count 3, 2, 1, 0; tc = 1 only in the cycle count first = 0; busy drops then; further en leaves count = 0 and tc = 0.
- Auto-reload with stalls: load 8'd2 mode 1, en toggling 1,0,1,1,1,1 -> count sequence 2, 1, 1, 0, 2, 1, 0; tc high exactly the two cycles count becomes 0.
- Load of zero: load 8'd0 mode 0 -> tc = 1 next cycle, state DONE. Load 8'd0 mode 1 with en = 1 for 3 cycles -> tc = 1 on each of the 3 cycles.
- Load priority: in RUN at count = 1, assert load = 1 with load_val = 8'hFF and en = 1 -> count = 8'hFF, tc = 0, busy = 1.
- Flags: two tc events with no clr -> tc_flag = 1, overrun = 1. clr_flag coincident with a third tc -> tc_flag = 1, overrun = 0. clr_flag alone -> both 0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and state type for the basic-blocks counter family.
package counter_pkg;

  localparam int CNT_W_DEFAULT = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/tff_sync.sv
// Single toggle flip-flop with synchronous parallel load.
module tff_sync (
  input  logic clk,
  input  logic reset,
  input  logic t,
  input  logic d_load,
  input  logic ld,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else if (ld) begin
      q <= d_load;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/down_counter_reload.sv
// Loadable down counter with one-shot / auto-reload modes,
// registered terminal-count pulse and sticky expiry flags.
module down_counter_reload
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode_in,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             tc_flag,
  output logic             overrun
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] reload_q;
  logic             mode_q;
  logic             tc_q;
  logic             tc_flag_q;
  logic             overrun_q;

  logic             step;
  logic             cnt_zero;
  logic             wrap;
  logic             ld_cnt;
  logic [WIDTH-1:0] d_cnt;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH:0]   zero_below;
  logic             new_zero;
  logic             tc_set;

  assign step = en & ~load & (state_q == S_RUN);

  // Borrow chain: bit i toggles once every lower bit is already zero.
  assign zero_below[0] = 1'b1;
  assign cnt_zero      = zero_below[WIDTH];

  assign wrap   = step & cnt_zero & (mode_q == MODE_RELOAD);
  assign ld_cnt = load | wrap;
  assign d_cnt  = load ? load_val : reload_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign zero_below[i+1] = zero_below[i] & ~count[i];
    assign t_vec[i]        = step & ~cnt_zero & zero_below[i];

    tff_sync u_tff (
      .clk    (clk),
      .reset  (reset),
      .t      (t_vec[i]),
      .d_load (d_cnt[i]),
      .ld     (ld_cnt),
      .q      (count[i])
    );
  end

  always_comb begin
    state_d  = state_q;
    new_zero = 1'b0;
    tc_set   = 1'b0;
    unique case (1'b1)
      load: begin
        new_zero = (load_val == '0);
        tc_set   = new_zero & (mode_in == MODE_ONESHOT);
        state_d  = tc_set ? S_DONE : S_RUN;
      end
      step: begin
        new_zero = cnt_zero ? (reload_q == '0)
                            : (count == WIDTH'(1));
        tc_set   = new_zero;
        if (new_zero && mode_q == MODE_ONESHOT) begin
          state_d = S_DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      reload_q  <= '0;
      mode_q    <= MODE_ONESHOT;
      tc_q      <= 1'b0;
      tc_flag_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (load) begin
        reload_q <= load_val;
        mode_q   <= mode_in;
      end
      state_q   <= state_d;
      tc_q      <= tc_set;
      tc_flag_q <= tc_set | (tc_flag_q & ~clr_flag);
      overrun_q <= (tc_set & tc_flag_q & ~clr_flag)
                 | (overrun_q & ~clr_flag);
    end
  end

  // RUN is the only encoding with bit 0 set, so busy is a pure flop output.
  assign busy    = state_q[0];
  assign tc      = tc_q;
  assign tc_flag = tc_flag_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_down_counter_reload.sv
// Bench for down_counter_reload: directed plan plus random traffic
// against a behavioural reference model.
module tb_down_counter_reload;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic         mode_in;
  logic         clr_flag;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;
  logic         tc_flag;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  // reference model: 0 idle, 1 running, 2 expired
  int m_count;
  int m_reload;
  int m_mode;
  int m_phase;
  int m_tc;
  int m_flag;
  int m_ov;

  down_counter_reload #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .mode_in  (mode_in),
    .clr_flag (clr_flag),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .tc_flag  (tc_flag),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_count  = 0;
    m_reload = 0;
    m_mode   = 0;
    m_phase  = 0;
    m_tc     = 0;
    m_flag   = 0;
    m_ov     = 0;
  endtask

  task automatic model_edge();
    int tcs;
    tcs = 0;
    if (load) begin
      m_reload = int'(load_val);
      m_mode   = int'(mode_in);
      m_count  = int'(load_val);
      if (load_val == 0 && mode_in == 1'b0) begin
        m_phase = 2;
        tcs     = 1;
      end else begin
        m_phase = 1;
      end
    end else if (m_phase == 1 && en) begin
      m_count = (m_count > 0) ? m_count - 1 : m_reload;
      tcs     = (m_count == 0) ? 1 : 0;
      if (tcs == 1 && m_mode == 0) m_phase = 2;
    end
    m_ov   = ((tcs & m_flag & ~int'(clr_flag)) | (m_ov & ~int'(clr_flag))) & 1;
    m_flag = (tcs | (m_flag & ~int'(clr_flag))) & 1;
    m_tc   = tcs;
  endtask

  task automatic check_all(input string tag);
    checks++;
    assert (count === W'(m_count)) else begin
      errors++;
      $error("FAIL %s count got %0d want %0d", tag, count, m_count);
    end
    checks++;
    assert (tc === 1'(m_tc)) else begin
      errors++;
      $error("FAIL %s tc got %0b want %0d", tag, tc, m_tc);
    end
    checks++;
    assert (busy === (m_phase == 1)) else begin
      errors++;
      $error("FAIL %s busy got %0b want %0d", tag, busy, m_phase == 1);
    end
    checks++;
    assert (tc_flag === 1'(m_flag)) else begin
      errors++;
      $error("FAIL %s tc_flag got %0b want %0d", tag, tc_flag, m_flag);
    end
    checks++;
    assert (overrun === 1'(m_ov)) else begin
      errors++;
      $error("FAIL %s overrun got %0b want %0d", tag, overrun, m_ov);
    end
  endtask

  task automatic lit(input string tag, input int got, input int want);
    checks++;
    assert (got == want) else begin
      errors++;
      $error("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic cyc(input string tag, input logic e, input logic ld,
                     input logic [W-1:0] lv, input logic mi,
                     input logic cl);
    en       = e;
    load     = ld;
    load_val = lv;
    mode_in  = mi;
    clr_flag = cl;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    int seq[6];
    int tcv[6];
    en = 0; load = 0; load_val = '0; mode_in = 0; clr_flag = 0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // reset mid-count
    cyc("rst_ld", 1'b0, 1'b1, 8'd5, 1'b0, 1'b0);
    cyc("rst_en0", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    cyc("rst_en1", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    lit("rst_pre", int'(count), 3);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    reset = 1'b0;
    cyc("rst_idle0", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    cyc("rst_idle1", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    lit("rst_idle_busy", int'(busy), 0);

    // one-shot 3 -> 0
    cyc("os_ld", 1'b1, 1'b1, 8'd3, 1'b0, 1'b0);
    lit("os_start", int'(count), 3);
    cyc("os_2", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    cyc("os_1", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    cyc("os_0", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    lit("os_tc", int'(tc), 1);
    lit("os_busy", int'(busy), 0);
    cyc("os_hold", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    lit("os_hold_tc", int'(tc), 0);
    lit("os_hold_cnt", int'(count), 0);
    cyc("os_clr", 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    // auto-reload with stalls
    seq = '{1, 1, 0, 2, 1, 0};
    tcv = '{0, 0, 1, 0, 0, 1};
    cyc("ar_ld", 1'b0, 1'b1, 8'd2, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc("ar_run", (i != 1), 1'b0, 8'd0, 1'b0, 1'b0);
      lit("ar_cnt", int'(count), seq[i]);
      lit("ar_tc", int'(tc), tcv[i]);
    end
    cyc("ar_clr", 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    // zero loads
    cyc("z_os", 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    lit("z_os_tc", int'(tc), 1);
    lit("z_os_busy", int'(busy), 0);
    cyc("z_os_after", 1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
    cyc("z_ar_ld", 1'b1, 1'b1, 8'd0, 1'b1, 1'b0);
    lit("z_ar_ld_tc", int'(tc), 0);
    for (int i = 0; i < 3; i++) begin
      cyc("z_ar_run", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
      lit("z_ar_tc", int'(tc), 1);
    end

    // flags: 3 tc events so far, set and overrun are sticky
    lit("fl_set", int'(tc_flag), 1);
    lit("fl_ov", int'(overrun), 1);
    cyc("fl_clr_tc", 1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
    lit("fl_clr_tc_flag", int'(tc_flag), 1);
    lit("fl_clr_tc_ov", int'(overrun), 0);
    cyc("fl_clr_only", 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    lit("fl_clr_flag", int'(tc_flag), 0);
    lit("fl_clr_ov", int'(overrun), 0);

    // load beats en at count 1
    cyc("pr_ld", 1'b0, 1'b1, 8'd5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc("pr_run", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    end
    lit("pr_at1", int'(count), 1);
    cyc("pr_load", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    lit("pr_cnt", int'(count), 255);
    lit("pr_tc", int'(tc), 0);
    lit("pr_busy", int'(busy), 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic e, ld, mi, cl;
      logic [W-1:0] lv;
      e  = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 15) == 0);
      mi = 1'($urandom_range(0, 1));
      cl = ($urandom_range(0, 9) == 0);
      lv = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                      : W'($urandom_range(0, 4));
      cyc("rand", e, ld, lv, mi, cl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
